i2s_mic_rx: RTL and testbench

- I2S master receiver for a stereo pair of digital MEMS microphones.
- Divides the audio clock to generate the bit clock (i2s_clk) and word-select (lrcl_clk).
- Shifts in serial mic_data and presents each complete 64-bit stereo frame (left 32 b, right 32 b) with a one-cycle valid strobe.
- Sits between the off-chip microphones and downstream audio DSP logic, all in the audio_clk domain.

---
 rtl/i2s_mic_rx.sv | 63 ++++++
 tb/tb_i2s_mic_rx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a stereo MEMS microphone pair: generates bit clock and
// word select from audio_clk and presents each 64-bit {left,right} frame with a valid strobe.
module i2s_mic_rx #(
  parameter int unsigned BCLK_HALF = 2
) (
  input  logic        audio_clk,
  input  logic        rst_in,
  input  logic        mic_data,
  output logic        lrcl_clk,
  output logic        i2s_clk,
  output logic        data_valid_out,
  output logic [63:0] audio_out
);

  localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_next;
  logic [63:0]      sr;
  logic [63:0]      sr_next;
  logic             primed;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign bit_next = bit_cnt + 6'd1;
  assign sr_next  = {sr[62:0], mic_data};

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      div_cnt        <= '0;
      bit_cnt        <= '0;
      sr             <= '0;
      primed         <= 1'b0;
      i2s_clk        <= 1'b0;
      lrcl_clk       <= 1'b0;
      data_valid_out <= 1'b0;
      audio_out      <= '0;
    end else begin
      data_valid_out <= 1'b0;
      if (div_wrap) begin
        div_cnt <= '0;
        i2s_clk <= ~i2s_clk;
        if (!i2s_clk) begin
          // Rise event: the slot-0 bit completes the previous frame's right word.
          sr     <= sr_next;
          primed <= 1'b1;
          if (bit_cnt == 6'd0 && primed) begin
            audio_out      <= sr_next;
            data_valid_out <= 1'b1;
          end
        end else begin
          bit_cnt  <= bit_next;
          lrcl_clk <= bit_next[5];
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Self-checking bench for i2s_mic_rx: two instances (BCLK_HALF=2 and 1) checked
// every audio_clk cycle against a timing/bit-history model derived from reset release.
module tb_i2s_mic_rx;

  localparam logic [63:0] PATTERN = 64'hA5A5_0001_8000_00FF;

  logic        clk = 1'b0;
  logic        rst0, mic0, i2s0, lr0, v0;
  logic        rst1, mic1, i2s1, lr1, v1;
  logic [63:0] a0, a1;

  int n_assert = 0;
  int n_fail   = 0;

  int          n_edges;
  bit          hist[$];
  logic [63:0] exp_audio;

  always #5 clk = ~clk;

  i2s_mic_rx #(.BCLK_HALF(2)) dut0 (
    .audio_clk(clk), .rst_in(rst0), .mic_data(mic0),
    .lrcl_clk(lr0), .i2s_clk(i2s0), .data_valid_out(v0), .audio_out(a0)
  );

  i2s_mic_rx #(.BCLK_HALF(1)) dut1 (
    .audio_clk(clk), .rst_in(rst1), .mic_data(mic1),
    .lrcl_clk(lr1), .i2s_clk(i2s1), .data_valid_out(v1), .audio_out(a1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic get_out(input int which, output logic i2s, output logic lr,
                         output logic v, output logic [63:0] a);
    if (which == 0) begin i2s = i2s0; lr = lr0; v = v0; a = a0; end
    else            begin i2s = i2s1; lr = lr1; v = v1; a = a1; end
  endtask

  task automatic set_mic(input int which, input logic b);
    if (which == 0) mic0 = b; else mic1 = b;
  endtask

  task automatic set_rst(input int which, input logic r);
    if (which == 0) rst0 = r; else rst1 = r;
  endtask

  function automatic bit gen_bit(input int mode, input int k);
    logic [63:0] w;
    int s;
    w = PATTERN;
    s = (k - 1) % 64;
    case (mode)
      0:       return 1'b1;
      1:       return (s == 0) ? w[0] : w[64 - s];
      default: return bit'($urandom % 2);
    endcase
  endfunction

  // Called at a negedge; asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset(input int which, input string tag);
    logic i2s, lr, v;
    logic [63:0] a;
    set_rst(which, 1'b0);
    #1;
    get_out(which, i2s, lr, v, a);
    check({tag, "_async_i2s"}, 64'(i2s), 64'd0);
    check({tag, "_async_lrcl"}, 64'(lr), 64'd0);
    check({tag, "_async_valid"}, 64'(v), 64'd0);
    check({tag, "_async_audio"}, a, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    get_out(which, i2s, lr, v, a);
    check({tag, "_held_valid"}, 64'(v), 64'd0);
    check({tag, "_held_audio"}, a, 64'd0);
    @(negedge clk);
    set_mic(which, 1'b0);
    set_rst(which, 1'b1);
    n_edges   = 0;
    hist.delete();
    exp_audio = '0;
  endtask

  // Starts and ends at a negedge. Edge nn after release: rise when nn % 2B == B.
  task automatic run(input int which, input int B, input int mode, input int ncycles,
                     input string tag);
    logic i2s, lr, v;
    logic [63:0] a;
    for (int c = 0; c < ncycles; c++) begin
      int  nn;
      int  k;
      bit  rise;
      bit  exp_v;
      nn   = n_edges + 1;
      rise = (nn % (2 * B)) == B;
      k    = (nn + B) / (2 * B);
      if (rise) begin
        bit b;
        b = gen_bit(mode, k);
        hist.push_back(b);
        set_mic(which, b);
      end
      @(posedge clk);
      n_edges = nn;
      #1;
      exp_v = rise && (k >= 65) && (((k - 1) % 64) == 0);
      if (exp_v) begin
        for (int j = 0; j < 64; j++) exp_audio[63 - j] = hist[k - 64 + j];
      end
      get_out(which, i2s, lr, v, a);
      check({tag, "_i2s"}, 64'(i2s), 64'((nn / B) % 2));
      check({tag, "_lrcl"}, 64'(lr), 64'(((nn / (2 * B)) % 64) >= 32));
      check({tag, "_valid"}, 64'(v), 64'(exp_v));
      check({tag, "_audio"}, a, exp_audio);
      if (exp_v && mode == 0) check({tag, "_ones"}, a, 64'hFFFF_FFFF_FFFF_FFFF);
      if (exp_v && mode == 1) check({tag, "_pattern"}, a, PATTERN);
      @(negedge clk);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; mic0 = 1'b0; mic1 = 1'b0;
    n_edges = 0; exp_audio = '0;
    @(negedge clk);

    do_reset(0, "rst_b2");
    run(0, 2, 0, 800, "const_b2");

    do_reset(0, "rst2_b2");
    run(0, 2, 1, 800, "pat_b2");

    do_reset(0, "rst3_b2");
    // 337 edges after release lands inside slot 20 of the second frame
    run(0, 2, 2, 337, "rand_b2");
    do_reset(0, "midrst_b2");
    run(0, 2, 2, 800, "post_b2");

    do_reset(1, "rst_b1");
    run(1, 1, 1, 520, "pat_b1");
    run(1, 1, 2, 300, "rand_b1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
